// File: rtl/dma_sched_pkg.sv
// Shared widths, FSM encoding and ring index helper
// for the DMA ring scheduler.
package dma_sched_pkg;

    localparam int ADR_W     = 28;
    localparam int DONE_W    = 16;
    localparam int IDX_MAX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic idx_wraps(
        input logic [IDX_MAX_W-1:0] idx,
        input logic [IDX_MAX_W:0]   num
    );
        logic [IDX_MAX_W:0] inc;
        inc = {1'b0, idx} + (IDX_MAX_W+1)'(1);
        return inc >= num;
    endfunction

endpackage

// File: rtl/dma_ring_scheduler_ring_ptr.sv
// Ring index with running buffer address;
// both wrap back to slot 0 / base after num slots.
module ring_ptr
    import dma_sched_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             init,
    input  logic             step,
    input  logic [ADR_W-1:0] base,
    input  logic [ADR_W-1:0] size,
    input  logic [IDX_W:0]   num,
    output logic [IDX_W-1:0] idx,
    output logic [ADR_W-1:0] adr
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             wrap;

    always_comb begin
        wrap  = idx_wraps(IDX_MAX_W'(idx_q), (IDX_MAX_W+1)'(num));
        idx_d = idx_q;
        adr_d = adr_q;
        if (init) begin
            idx_d = '0;
            adr_d = base;
        end else if (step) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
            adr_d = wrap ? base : adr_q + size;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q <= '0;
            adr_q <= '0;
        end else begin
            idx_q <= idx_d;
            adr_q <= adr_d;
        end
    end

    assign idx = idx_q;
    assign adr = adr_q;

endmodule

// File: rtl/dma_ring_scheduler.sv
// Issues simple_dma commands round a ring of capture buffers
// and hands completed buffers to the host in order.
module dma_ring_scheduler
    import dma_sched_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic [ADR_W-1:0]  CFG_BASE_ADR,
    input  logic [ADR_W-1:0]  CFG_BUF_SIZE,
    input  logic [IDX_W:0]    CFG_NUM_BUFS,
    output logic              DMA_START,
    output logic [ADR_W-1:0]  DMA_START_ADR,
    output logic [ADR_W-1:0]  DMA_BUF_SIZE,
    input  logic [DONE_W-1:0] DMA_DONE_CNT,
    output logic              FULL_VALID,
    output logic [IDX_W-1:0]  FULL_IDX,
    output logic [ADR_W-1:0]  FULL_ADR,
    input  logic              RELEASE,
    output logic              BUSY,
    output logic              STALL,
    output logic              CFG_ERR
);

    localparam int CNT_W = IDX_W + 2;
    localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(1 << IDX_W);

    state_e             state_q, state_d;
    logic               en_prev_q, en_prev_d;
    logic               pend_q, pend_d;
    logic               rst_seen_q, rst_seen_d;
    logic               cfg_err_q, cfg_err_d;
    logic [ADR_W-1:0]   base_q, base_d;
    logic [ADR_W-1:0]   size_q, size_d;
    logic [IDX_W:0]     num_q, num_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   full_cnt_q, full_cnt_d;
    logic [DONE_W-1:0]  done_prev_q, done_prev_d;
    logic [ADR_W-1:0]   dma_adr_q, dma_adr_d;
    logic [ADR_W-1:0]   dma_size_q, dma_size_d;

    logic               wait_cfg, latch, run, go;
    logic               issue, done_evt, out_dec, rel;
    logic [CNT_W-1:0]   free;
    logic [ADR_W-1:0]   ptr_base;
    logic [ADR_W-1:0]   wr_adr;
    logic [ADR_W-1:0]   rd_adr;
    logic [IDX_W-1:0]   rd_idx;

    always_comb begin
        wait_cfg = (ENABLE & ~en_prev_q) | pend_q;
        latch    = ENABLE & wait_cfg & (out_cnt_q == '0);
        run      = ENABLE & ~cfg_err_q & ~wait_cfg;
        free     = CNT_W'(num_q) - out_cnt_q - full_cnt_q;
        issue    = (state_q == ST_ISSUE);
        done_evt = rst_seen_q & (DMA_DONE_CNT != done_prev_q);
        out_dec  = done_evt & (out_cnt_q != '0);
        rel      = RELEASE & (full_cnt_q != '0);
        ptr_base = latch ? CFG_BASE_ADR : base_q;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run && free != '0 && out_cnt_q < CNT_W'(MAX_OUT))
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        go = (state_q == ST_IDLE) & (state_d == ST_ISSUE);

        en_prev_d   = ENABLE;
        pend_d      = ENABLE & wait_cfg & ~latch;
        rst_seen_d  = 1'b1;
        done_prev_d = DMA_DONE_CNT;
        base_d      = latch ? CFG_BASE_ADR : base_q;
        size_d      = latch ? CFG_BUF_SIZE : size_q;
        num_d       = latch ? CFG_NUM_BUFS : num_q;
        cfg_err_d   = cfg_err_q;
        if (latch)
            cfg_err_d = (CFG_BUF_SIZE == '0) | (CFG_NUM_BUFS == '0)
                      | (CFG_NUM_BUFS > NUM_MAX);

        // Issue, completion and release are independent +/-1 terms.
        out_cnt_d  = out_cnt_q + CNT_W'(issue) - CNT_W'(out_dec);
        full_cnt_d = full_cnt_q + CNT_W'(out_dec) - CNT_W'(rel);
        if (latch)
            full_cnt_d = '0;

        dma_adr_d  = go ? wr_adr : dma_adr_q;
        dma_size_d = go ? size_q : dma_size_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            en_prev_q   <= 1'b0;
            pend_q      <= 1'b0;
            rst_seen_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            num_q       <= '0;
            out_cnt_q   <= '0;
            full_cnt_q  <= '0;
            done_prev_q <= '0;
            dma_adr_q   <= '0;
            dma_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_prev_q   <= en_prev_d;
            pend_q      <= pend_d;
            rst_seen_q  <= rst_seen_d;
            cfg_err_q   <= cfg_err_d;
            base_q      <= base_d;
            size_q      <= size_d;
            num_q       <= num_d;
            out_cnt_q   <= out_cnt_d;
            full_cnt_q  <= full_cnt_d;
            done_prev_q <= done_prev_d;
            dma_adr_q   <= dma_adr_d;
            dma_size_q  <= dma_size_d;
        end
    end

    ring_ptr #(.IDX_W(IDX_W)) u_wr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .init  (latch),
        .step  (issue),
        .base  (ptr_base),
        .size  (size_q),
        .num   (num_q),
        .idx   (),
        .adr   (wr_adr)
    );

    ring_ptr #(.IDX_W(IDX_W)) u_rd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .init  (latch),
        .step  (rel),
        .base  (ptr_base),
        .size  (size_q),
        .num   (num_q),
        .idx   (rd_idx),
        .adr   (rd_adr)
    );

    assign DMA_START     = issue;
    assign DMA_START_ADR = dma_adr_q;
    assign DMA_BUF_SIZE  = dma_size_q;
    assign FULL_VALID    = (full_cnt_q != '0);
    assign FULL_IDX      = rd_idx;
    assign FULL_ADR      = rd_adr;
    assign BUSY          = ENABLE | (out_cnt_q != '0);
    assign STALL         = run & (free == '0);
    assign CFG_ERR       = cfg_err_q;

endmodule

// File: tb/tb_dma_ring_scheduler.sv
// Directed bench: expected START addresses are queued by the
// stimulus and popped by a negedge monitor on every START cycle.
module tb_dma_ring_scheduler;

    localparam int IDX_W = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              ENABLE = 1'b0;
    logic              RELEASE = 1'b0;
    logic [27:0]       CFG_BASE_ADR = '0;
    logic [27:0]       CFG_BUF_SIZE = '0;
    logic [IDX_W:0]    CFG_NUM_BUFS = '0;
    logic [15:0]       DMA_DONE_CNT = '0;
    logic              DMA_START;
    logic [27:0]       DMA_START_ADR;
    logic [27:0]       DMA_BUF_SIZE;
    logic              FULL_VALID;
    logic [IDX_W-1:0]  FULL_IDX;
    logic [27:0]       FULL_ADR;
    logic              BUSY;
    logic              STALL;
    logic              CFG_ERR;

    int          total = 0;
    int          bad = 0;
    int          n_start = 0;
    logic [27:0] exp_q[$];
    logic [27:0] exp_size = '0;
    logic        prev_start = 1'b0;

    dma_ring_scheduler #(.IDX_W(IDX_W), .MAX_OUT(4)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .ENABLE        (ENABLE),
        .CFG_BASE_ADR  (CFG_BASE_ADR),
        .CFG_BUF_SIZE  (CFG_BUF_SIZE),
        .CFG_NUM_BUFS  (CFG_NUM_BUFS),
        .DMA_START     (DMA_START),
        .DMA_START_ADR (DMA_START_ADR),
        .DMA_BUF_SIZE  (DMA_BUF_SIZE),
        .DMA_DONE_CNT  (DMA_DONE_CNT),
        .FULL_VALID    (FULL_VALID),
        .FULL_IDX      (FULL_IDX),
        .FULL_ADR      (FULL_ADR),
        .RELEASE       (RELEASE),
        .BUSY          (BUSY),
        .STALL         (STALL),
        .CFG_ERR       (CFG_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every START cycle consumes one queued address.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_start = 1'b0;
        end else begin
            if (DMA_START) begin
                n_start++;
                chk("start_pulse_gap", prev_start, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected: adr 0x%0h, none queued",
                             DMA_START_ADR);
                end else begin
                    chk("start_adr", DMA_START_ADR, exp_q.pop_front());
                    chk("start_size", DMA_BUF_SIZE, exp_size);
                end
            end
            prev_start = DMA_START;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input logic [15:0] d);
        @(negedge CLK);
        RST_N = 1'b0;
        ENABLE = 1'b0;
        RELEASE = 1'b0;
        DMA_DONE_CNT = d;
        exp_q.delete();
        idle(2);
        n_start = 0;
        RST_N = 1'b1;
        idle(1);
    endtask

    task automatic start_ring(input logic [27:0] base,
                              input logic [27:0] size,
                              input logic [IDX_W:0] num);
        CFG_BASE_ADR = base;
        CFG_BUF_SIZE = size;
        CFG_NUM_BUFS = num;
        exp_size = size;
        ENABLE = 1'b1;
    endtask

    task automatic pulse_done;
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        idle(1);
    endtask

    task automatic release_buf;
        RELEASE = 1'b1;
        idle(1);
        RELEASE = 1'b0;
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (n_start < n && k < 200) begin
            idle(1);
            k++;
        end
        chk("start_count", n_start, n);
    endtask

    task automatic wait_start_high;
        int k = 0;
        while (!DMA_START && k < 100) begin
            idle(1);
            k++;
        end
        chk("start_seen", DMA_START, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int seen;
        int k;

        // Reset values
        do_reset(16'h0000);
        chk("rst_start", DMA_START, 0);
        chk("rst_start_adr", DMA_START_ADR, 0);
        chk("rst_buf_size", DMA_BUF_SIZE, 0);
        chk("rst_full_valid", FULL_VALID, 0);
        chk("rst_full_adr", FULL_ADR, 0);
        chk("rst_stall", STALL, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cfg_err", CFG_ERR, 0);

        // 3-buffer ring, reuse of slot 0 only after release
        exp_q.push_back(28'h100);
        exp_q.push_back(28'h140);
        exp_q.push_back(28'h180);
        start_ring(28'h100, 28'h40, 5'd3);
        wait_starts(3);
        idle(5);
        chk("ring3_stall", STALL, 1);
        chk("ring3_fv_pre", FULL_VALID, 0);
        pulse_done();
        pulse_done();
        pulse_done();
        chk("ring3_fv", FULL_VALID, 1);
        chk("ring3_idx0", FULL_IDX, 0);
        chk("ring3_adr0", FULL_ADR, 28'h100);
        chk("ring3_no_reuse", n_start, 3);
        exp_q.push_back(28'h100);
        release_buf();
        chk("ring3_idx1", FULL_IDX, 1);
        chk("ring3_adr1", FULL_ADR, 28'h140);
        wait_starts(4);
        exp_q.push_back(28'h140);
        release_buf();
        chk("ring3_idx2", FULL_IDX, 2);
        chk("ring3_adr2", FULL_ADR, 28'h180);
        wait_starts(5);
        idle(10);
        chk("ring3_final_count", n_start, 5);
        chk("ring3_queue", exp_q.size(), 0);

        // MAX_OUT limit with 8 buffers and no completions
        do_reset(16'h0000);
        exp_q.push_back(28'h000);
        exp_q.push_back(28'h010);
        exp_q.push_back(28'h020);
        exp_q.push_back(28'h030);
        start_ring(28'h000, 28'h10, 5'd8);
        wait_starts(4);
        idle(20);
        chk("maxout_count", n_start, 4);
        chk("maxout_stall", STALL, 0);
        chk("maxout_busy", BUSY, 1);
        chk("maxout_fv", FULL_VALID, 0);

        // 2 buffers both full: stall until host releases
        do_reset(16'h0000);
        exp_q.push_back(28'h200);
        exp_q.push_back(28'h220);
        start_ring(28'h200, 28'h20, 5'd2);
        wait_starts(2);
        idle(4);
        pulse_done();
        pulse_done();
        chk("two_fv", FULL_VALID, 1);
        chk("two_stall", STALL, 1);
        idle(10);
        chk("two_no_third", n_start, 2);
        exp_q.push_back(28'h200);
        release_buf();
        wait_starts(3);
        chk("two_idx", FULL_IDX, 1);
        chk("two_adr", FULL_ADR, 28'h220);

        // Issue, completion and release in the same cycle
        do_reset(16'h0000);
        exp_q.push_back(28'h000);
        exp_q.push_back(28'h010);
        exp_q.push_back(28'h020);
        exp_q.push_back(28'h030);
        start_ring(28'h000, 28'h10, 5'd8);
        wait_starts(4);
        idle(4);
        exp_q.push_back(28'h040);
        exp_q.push_back(28'h050);
        pulse_done();
        wait_start_high();
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        release_buf();
        chk("same_fv", FULL_VALID, 1);
        chk("same_idx", FULL_IDX, 1);
        chk("same_adr", FULL_ADR, 28'h010);
        wait_starts(6);
        idle(20);
        chk("same_out_cnt", n_start, 6);
        release_buf();
        chk("same_full_cnt", FULL_VALID, 0);

        // DONE_CNT wrap from 0xFFFF counts once
        do_reset(16'hFFFF);
        exp_q.push_back(28'h300);
        start_ring(28'h300, 28'h8, 5'd1);
        wait_starts(1);
        idle(3);
        chk("wrap_fv_pre", FULL_VALID, 0);
        chk("wrap_stall", STALL, 1);
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        idle(3);
        chk("wrap_fv", FULL_VALID, 1);
        chk("wrap_adr", FULL_ADR, 28'h300);
        exp_q.push_back(28'h300);
        release_buf();
        chk("wrap_single", FULL_VALID, 0);
        wait_starts(2);

        // Bad config, drain with ENABLE low, async reset
        do_reset(16'h0000);
        start_ring(28'h1000, 28'h0, 5'd4);
        idle(10);
        chk("err_flag", CFG_ERR, 1);
        chk("err_no_start", n_start, 0);
        chk("err_stall", STALL, 0);
        ENABLE = 1'b0;
        idle(1);
        exp_size = 28'h40;
        CFG_BUF_SIZE = 28'h40;
        exp_q.push_back(28'h1000);
        exp_q.push_back(28'h1040);
        ENABLE = 1'b1;
        seen = 0;
        k = 0;
        while (seen < 2 && k < 200) begin
            idle(1);
            k++;
            if (DMA_START) seen++;
        end
        ENABLE = 1'b0;
        chk("err_cleared", CFG_ERR, 0);
        idle(5);
        chk("drain_count", n_start, 2);
        chk("drain_busy2", BUSY, 1);
        pulse_done();
        chk("drain_busy1", BUSY, 1);
        pulse_done();
        chk("drain_busy0", BUSY, 0);
        chk("drain_fv", FULL_VALID, 1);
        exp_q.push_back(28'h1000);
        ENABLE = 1'b1;
        wait_start_high();
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_start", DMA_START, 0);
        chk("async_fv", FULL_VALID, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
